tft_ili9341_spi_rx: RTL
=======================

// Module: tft_ili9341_spi_rx
// PURPOSE
//  Receive side of the ILI9341 4-wire SPI + DC link: oversamples tft_sck/sdi/dc/cs in sysClk domain,
//  rebuilds 9-bit words {dc, byte[7:0]} (MSB first) and queues them in a small FIFO with valid/ready
//  output. Tracks current command and parameter index. Used as display-side model / link monitor.
// PARAMETERS
//  SYNC_STAGES  2  synchronizer flops on each SPI input (>=2)
//  FIFO_DEPTH   8  word FIFO entries (power of 2, >=2)
//  CNT_W        8  width of paramIdx and errCount (saturating)
// PORTS
//  sysClk      in   1      system clock; must be >= 3x spiClk of the transmitter
//  rstN        in   1      asynchronous active-low reset
//  tft_sck     in   1      SPI clock, idles high, data sampled on rising edge
//  tft_sdi     in   1      serial data, MSB first
//  tft_dc      in   1      0 = command byte, 1 = data/parameter byte
//  tft_cs      in   1      chip select, active low
//  wordOut     out  9      {dc, byte} at FIFO head
//  wordValid   out  1      FIFO non-empty
//  wordReady   in   1      consumer accepts head when wordValid & wordReady
//  lastCmd     out  8      most recent command byte (dc=0)
//  paramIdx    out  CNT_W  data bytes received since lastCmd, saturating
//  overflow    out  1      sticky: word dropped because FIFO full
//  clearFlags  in   1      synchronous clear of overflow (and frameError/errCount if enabled)
// BEHAVIOUR
//  - Reset: wordOut=0, wordValid=0, lastCmd=0x00, paramIdx=0, overflow=0, FIFO empty, bitCnt=0,
//    sync flops preset to idle (sck=1, cs=1). Reset mid-byte discards partial byte.
//  - Inputs pass SYNC_STAGES flops; edges detected on last two synchronized samples.
//  - csActive = ~cs_sync. cs falling edge: bitCnt<=0, shift reg cleared.
//  - sck rising edge with csActive: shift <= {shift[6:0], sdi}; bitCnt++ (3-bit, wraps 7->0).
//    On 8th bit (bitCnt==7): dc sampled at this edge, word {dc, shift[6:0], sdi} written to FIFO
//    next cycle. Back-to-back bytes with cs held low are supported (counter wraps).
//  - sck edges while cs high ignored. cs rising with bitCnt!=0: partial byte discarded, bitCnt<=0.
//  - Latency: 8th synchronized rising edge detect at cycle N -> FIFO write N+1 -> wordValid=1 at N+2.
//  - FIFO: show-ahead; wordOut valid whenever wordValid. Pop on wordValid&wordReady.
//    Push and pop same cycle when full: both happen, no overflow. Push when full w/o pop: word
//    dropped, overflow<=1 (held until clearFlags). Pop when empty: ignored.
//  - Command tracking on each completed word (even if dropped by FIFO):
//    dc=0 -> lastCmd<=byte, paramIdx<=0; dc=1 -> paramIdx<=paramIdx+1, saturates at 2^CNT_W-1.
//  - clearFlags and overflow set in same cycle: set wins.
// CONFIGURATION
//  FRAME_ERR_EN defined: adds outputs frameError (1b, sticky) and errCount (CNT_W, saturating);
//    cs rising with bitCnt!=0 sets frameError and increments errCount; both cleared by clearFlags
//    (set wins over clear). Reset value 0.
//  FRAME_ERR_EN undefined: ports absent; partial bytes silently discarded.
// TESTING
//  1 cs low, send cmd 0x2A (dc=0) then 0x00,0x10 (dc=1), cs high -> words 0x02A,0x100,0x110 in
//    order; lastCmd=0x2A, paramIdx=2.
//  2 wordReady=0, send FIFO_DEPTH+1 bytes -> first 8 held, 9th dropped, overflow=1;
//    clearFlags pulse -> overflow=0.
//  3 FIFO full, wordReady=1 on cycle 9th word is written -> no overflow, 8 entries, order kept.
//  4 cs high after 5 bits, then full byte 0xA5 dc=1 -> only 0x1A5 queued; with FRAME_ERR_EN
//    frameError=1, errCount=1.
//  5 Assert rstN=0 mid-byte (bit 4) -> all outputs reset values; next full byte 0x3C received cleanly.
//  6 300 data bytes after cmd 0x2C -> paramIdx saturates at 255, lastCmd=0x2C.

Source files
------------

// File: rtl/tft_ili9341_spi_rx.sv
// ILI9341 4-wire SPI + DC receiver: oversampled link, 9-bit {dc, byte} word FIFO, command/parameter tracking.
// Optional build macro FRAME_ERR_EN adds frameError/errCount reporting of truncated bytes.
module tft_ili9341_spi_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 8
) (
    input  logic             sysClk,
    input  logic             rstN,
    input  logic             tft_sck,
    input  logic             tft_sdi,
    input  logic             tft_dc,
    input  logic             tft_cs,
    output logic [8:0]       wordOut,
    output logic             wordValid,
    input  logic             wordReady,
    output logic [7:0]       lastCmd,
    output logic [CNT_W-1:0] paramIdx,
    output logic             overflow,
`ifdef FRAME_ERR_EN
    output logic             frameError,
    output logic [CNT_W-1:0] errCount,
`endif
    input  logic             clearFlags
);

    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] sckSync, sdiSync, dcSync, csSync;
    logic                   sckPrev, csPrev;
    logic                   sckS, sdiS, dcS, csS;
    logic                   sckRise, csFall, csRise, csActive, partialDrop;

    // Sync flops preset to the idle bus state so reset never fakes an edge.
    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            sckSync <= '1;
            csSync  <= '1;
            sdiSync <= '0;
            dcSync  <= '0;
            sckPrev <= 1'b1;
            csPrev  <= 1'b1;
        end else begin
            sckSync <= {sckSync[SYNC_STAGES-2:0], tft_sck};
            csSync  <= {csSync[SYNC_STAGES-2:0], tft_cs};
            sdiSync <= {sdiSync[SYNC_STAGES-2:0], tft_sdi};
            dcSync  <= {dcSync[SYNC_STAGES-2:0], tft_dc};
            sckPrev <= sckSync[SYNC_STAGES-1];
            csPrev  <= csSync[SYNC_STAGES-1];
        end
    end

    assign sckS        = sckSync[SYNC_STAGES-1];
    assign sdiS        = sdiSync[SYNC_STAGES-1];
    assign dcS         = dcSync[SYNC_STAGES-1];
    assign csS         = csSync[SYNC_STAGES-1];
    assign sckRise     = sckS & ~sckPrev;
    assign csFall      = ~csS & csPrev;
    assign csRise      = csS & ~csPrev;
    assign csActive    = ~csS;

    logic [2:0] bitCnt;
    logic [6:0] shiftReg;
    logic       pendValid;
    logic [8:0] pendWord;

    assign partialDrop = csRise && (bitCnt != 3'd0);

    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            bitCnt    <= '0;
            shiftReg  <= '0;
            pendValid <= 1'b0;
            pendWord  <= '0;
        end else begin
            pendValid <= 1'b0;
            if (csFall) begin
                bitCnt   <= '0;
                shiftReg <= '0;
            end else if (csRise) begin
                bitCnt <= '0;
            end else if (sckRise && csActive) begin
                shiftReg <= {shiftReg[5:0], sdiS};
                bitCnt   <= bitCnt + 3'd1;
                if (bitCnt == 3'd7) begin
                    pendValid <= 1'b1;
                    pendWord  <= {dcS, shiftReg, sdiS};
                end
            end
        end
    end

    // Tracking follows every completed word, including ones the FIFO drops.
    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            lastCmd  <= '0;
            paramIdx <= '0;
        end else if (pendValid) begin
            if (!pendWord[8]) begin
                lastCmd  <= pendWord[7:0];
                paramIdx <= '0;
            end else if (paramIdx != '1) begin
                paramIdx <= paramIdx + 1'b1;
            end
        end
    end

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   count;
    logic          full, pop, doWrite, dropped;

    assign full      = (count == FULL_CNT);
    assign wordValid = (count != '0);
    assign pop       = wordValid & wordReady;
    assign doWrite   = pendValid & (~full | pop);
    assign dropped   = pendValid & full & ~pop;

    // NOTE: storage has no reset; wordOut is gated by wordValid so stale contents never show.
    always_ff @(posedge sysClk) begin
        if (doWrite) mem[wrPtr] <= pendWord;
    end

    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + 1'b1;
            if (pop)     rdPtr <= rdPtr + 1'b1;
            case ({doWrite, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (dropped)         overflow <= 1'b1;
            else if (clearFlags) overflow <= 1'b0;
        end
    end

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        wordOut = '0;
        if (wordValid) wordOut = mem[rdPtr];
    end

`ifdef FRAME_ERR_EN
    always_ff @(posedge sysClk or negedge rstN) begin
        if (!rstN) begin
            frameError <= 1'b0;
            errCount   <= '0;
        end else if (partialDrop) begin
            frameError <= 1'b1;
            if (errCount != '1) errCount <= errCount + 1'b1;
        end else if (clearFlags) begin
            frameError <= 1'b0;
            errCount   <= '0;
        end
    end
`else
    logic unusedDrop;
    assign unusedDrop = partialDrop;
`endif

endmodule
